// File: rtl/memory_master.sv
// memory_master: valid/ready bus-master front end for the negedge-clocked Memory BRAM.
// Drives active-low Mem_En / Mem_Write_EN strobes, returns captured read data.
// Optional feature macro: MEMORY_MASTER_BURST_EN (multi-beat incrementing bursts).
module memory_master #(
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned DataWidth = 16,
    parameter int unsigned LenWidth  = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Req_Valid,
    output logic                 Req_Ready,
    input  logic                 Req_Write,
    input  logic [AddrWidth-1:0] Req_Addr,
    input  logic [LenWidth-1:0]  Req_Len,
    input  logic [DataWidth-1:0] Wr_Data,
    input  logic                 Wr_Valid,
    output logic                 Wr_Ready,
    output logic [DataWidth-1:0] Rd_Data,
    output logic                 Rd_Valid,
    input  logic                 Rd_Ready,
    output logic                 Busy,
    output logic [DataWidth-1:0] Mem_DIn,
    output logic [AddrWidth-1:0] Mem_Address,
    output logic                 Mem_Write_EN,
    output logic                 Mem_En,
    input  logic [DataWidth-1:0] Mem_DOut
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_RD_ISSUE = 2'd2,
        S_RD_WAIT  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   req_ready_q, req_ready_d;
    logic                   wr_ready_q, wr_ready_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [DataWidth-1:0]   rd_data_q, rd_data_d;
    logic                   busy_q, busy_d;
    logic [DataWidth-1:0]   mem_din_q, mem_din_d;
    logic [AddrWidth-1:0]   mem_addr_q, mem_addr_d;
    logic                   mem_we_n_q, mem_we_n_d;
    logic                   mem_en_n_q, mem_en_n_d;

    logic                   req_fire_c;
    logic                   wr_fire_c;
    logic                   rd_fire_c;
    logic                   last_beat_c;
    logic [AddrWidth-1:0]   addr_inc_c;

`ifdef MEMORY_MASTER_BURST_EN
    logic [LenWidth-1:0]    beats_q, beats_d;

    // Burst bookkeeping: remaining beats and wrapping address increment
    assign last_beat_c = (beats_q == '0);
    assign addr_inc_c  = AddrWidth'(addr_q + 1'b1);
`else
    logic                   unused_len_c;

    // Single-beat build: Req_Len is ignored and the address never advances
    assign last_beat_c  = 1'b1;
    assign addr_inc_c   = addr_q;
    assign unused_len_c = ^Req_Len;
`endif

    // Handshake qualifiers, each only meaningful in its own state
    assign req_fire_c = (state_q == S_IDLE)    && Req_Valid && req_ready_q;
    assign wr_fire_c  = (state_q == S_WRITE)   && Wr_Valid  && wr_ready_q;
    assign rd_fire_c  = (state_q == S_RD_WAIT) && rd_valid_q && Rd_Ready;

    // State and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            req_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
            mem_din_q   <= '0;
            mem_addr_q  <= '0;
            mem_we_n_q  <= 1'b1;
            mem_en_n_q  <= 1'b1;
`ifdef MEMORY_MASTER_BURST_EN
            beats_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
            mem_din_q   <= mem_din_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_n_q  <= mem_we_n_d;
            mem_en_n_q  <= mem_en_n_d;
`ifdef MEMORY_MASTER_BURST_EN
            beats_q     <= beats_d;
`endif
        end
    end

    // Next-state logic; WRITE holds one extra cycle (Wr_Ready low) to cover the final strobe
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_fire_c) begin
                    state_d = Req_Write ? S_WRITE : S_RD_ISSUE;
                end
            end
            S_WRITE: begin
                if (!wr_ready_q) begin
                    state_d = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rd_fire_c) begin
                    state_d = last_beat_c ? S_IDLE : S_RD_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values; strobes default to inactive every cycle
    always_comb begin
        addr_d      = addr_q;
        req_ready_d = req_ready_q;
        wr_ready_d  = wr_ready_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        busy_d      = busy_q;
        mem_din_d   = mem_din_q;
        mem_addr_d  = mem_addr_q;
        mem_we_n_d  = 1'b1;
        mem_en_n_d  = 1'b1;
`ifdef MEMORY_MASTER_BURST_EN
        beats_d     = beats_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_fire_c) begin
                    addr_d      = Req_Addr;
`ifdef MEMORY_MASTER_BURST_EN
                    beats_d     = Req_Len;
`endif
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (Req_Write) begin
                        wr_ready_d = 1'b1;
                    end else begin
                        mem_en_n_d = 1'b0;
                        mem_addr_d = Req_Addr;
                    end
                end
            end
            S_WRITE: begin
                if (wr_fire_c) begin
                    mem_en_n_d = 1'b0;
                    mem_we_n_d = 1'b0;
                    mem_addr_d = addr_q;
                    mem_din_d  = Wr_Data;
                    addr_d     = addr_inc_c;
`ifdef MEMORY_MASTER_BURST_EN
                    beats_d    = LenWidth'(beats_q - 1'b1);
`endif
                    if (last_beat_c) begin
                        wr_ready_d = 1'b0;
                    end
                end
                if (!wr_ready_q) begin
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            S_RD_ISSUE: begin
                rd_data_d  = Mem_DOut;
                rd_valid_d = 1'b1;
            end
            S_RD_WAIT: begin
                if (rd_fire_c) begin
                    rd_valid_d = 1'b0;
                    if (last_beat_c) begin
                        req_ready_d = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        addr_d     = addr_inc_c;
`ifdef MEMORY_MASTER_BURST_EN
                        beats_d    = LenWidth'(beats_q - 1'b1);
`endif
                        mem_en_n_d = 1'b0;
                        mem_addr_d = addr_inc_c;
                    end
                end
            end
            default: begin
                req_ready_d = 1'b0;
            end
        endcase
    end

    assign Req_Ready    = req_ready_q;
    assign Wr_Ready     = wr_ready_q;
    assign Rd_Valid     = rd_valid_q;
    assign Rd_Data      = rd_data_q;
    assign Busy         = busy_q;
    assign Mem_DIn      = mem_din_q;
    assign Mem_Address  = mem_addr_q;
    assign Mem_Write_EN = mem_we_n_q;
    assign Mem_En       = mem_en_n_q;

endmodule

// File: tb/tb_memory_master.sv
// Testbench for memory_master: negedge BRAM model plus an array reference of expected contents.
module tb_memory_master;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned LW = 4;
    localparam int unsigned DEPTH = 1 << AW;
`ifdef MEMORY_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Req_Valid = 1'b0;
    logic          Req_Ready;
    logic          Req_Write = 1'b0;
    logic [AW-1:0] Req_Addr = '0;
    logic [LW-1:0] Req_Len = '0;
    logic [DW-1:0] Wr_Data = '0;
    logic          Wr_Valid = 1'b0;
    logic          Wr_Ready;
    logic [DW-1:0] Rd_Data;
    logic          Rd_Valid;
    logic          Rd_Ready = 1'b0;
    logic          Busy;
    logic [DW-1:0] Mem_DIn;
    logic [AW-1:0] Mem_Address;
    logic          Mem_Write_EN;
    logic          Mem_En;
    logic [DW-1:0] Mem_DOut = '0;

    logic [DW-1:0] bram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned en_cnt = 0;
    int unsigned viol = 0;

    always #5 Clk = ~Clk;

    memory_master dut (
        .Clk(Clk), .Reset(Reset),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
        .Req_Addr(Req_Addr), .Req_Len(Req_Len),
        .Wr_Data(Wr_Data), .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready),
        .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready),
        .Busy(Busy),
        .Mem_DIn(Mem_DIn), .Mem_Address(Mem_Address), .Mem_Write_EN(Mem_Write_EN),
        .Mem_En(Mem_En), .Mem_DOut(Mem_DOut)
    );

    // Negedge single-port BRAM; also counts strobes and strobe-rule violations
    always @(negedge Clk) begin
        if (!Mem_En) begin
            en_cnt++;
            if (!Mem_Write_EN) bram[Mem_Address] = Mem_DIn;
            else               Mem_DOut = bram[Mem_Address];
        end else if (!Mem_Write_EN) begin
            viol++;
        end
        if (Req_Ready && !Mem_En) viol++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_req_ready();
        int n = 0;
        while (!Req_Ready && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready_wait", 32'(Req_Ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(Req_Ready), 32'd0);
        chk({tag, "_wr_ready"}, 32'(Wr_Ready), 32'd0);
        chk({tag, "_rd_valid"}, 32'(Rd_Valid), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_mem_en"}, 32'(Mem_En), 32'd1);
        chk({tag, "_mem_we"}, 32'(Mem_Write_EN), 32'd1);
        chk({tag, "_mem_addr"}, 32'(Mem_Address), 32'd0);
        chk({tag, "_mem_din"}, 32'(Mem_DIn), 32'd0);
        chk({tag, "_rd_data"}, 32'(Rd_Data), 32'd0);
    endtask

    // Write burst: data is d0+i when seq, else random; gap_pct = chance of idle cycles before a beat
    task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] len,
                            input logic [DW-1:0] d0, input bit seq, input int gap_pct);
        int nb;
        int g;
        int unsigned e0;
        logic [DW-1:0] d;
        logic [AW-1:0] ad;
        nb = BURST ? int'(len) + 1 : 1;
        wait_req_ready();
        Req_Valid = 1'b1; Req_Write = 1'b1; Req_Addr = a; Req_Len = len;
        tick();
        Req_Valid = 1'b0; Req_Write = 1'b0; Req_Addr = AW'($urandom); Req_Len = LW'($urandom);
        e0 = en_cnt;
        chk("wr_busy", 32'(Busy), 32'd1);
        chk("wr_req_ready_low", 32'(Req_Ready), 32'd0);
        for (int i = 0; i < nb; i++) begin
            g = ($urandom_range(99) < 32'(gap_pct)) ? int'($urandom_range(3, 1)) : 0;
            for (int j = 0; j < g; j++) begin
                Wr_Valid = 1'b0; Wr_Data = DW'($urandom);
                tick();
                chk("wr_gap_no_strobe", 32'({Mem_En, Mem_Write_EN}), 32'd3);
            end
            chk("wr_ready", 32'(Wr_Ready), 32'd1);
            d = seq ? DW'(int'(d0) + i) : DW'($urandom);
            ad = AW'(int'(a) + i);
            Wr_Valid = 1'b1; Wr_Data = d;
            tick();
            chk("wr_strobe_en", 32'({Mem_En, Mem_Write_EN}), 32'd0);
            chk("wr_strobe_addr", 32'(Mem_Address), 32'(ad));
            chk("wr_strobe_din", 32'(Mem_DIn), 32'(d));
            ref_mem[ad] = d;
        end
        Wr_Valid = 1'b0;
        chk("wr_ready_drop", 32'(Wr_Ready), 32'd0);
        tick();
        chk("wr_idle_req_ready", 32'(Req_Ready), 32'd1);
        chk("wr_idle_busy", 32'(Busy), 32'd0);
        chk("wr_strobe_count", en_cnt - e0, 32'(nb));
    endtask

    // Read burst with consumer stalls of smin..smax cycles per beat
    task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] len,
                           input int smin, input int smax);
        int nb;
        int s;
        int unsigned e0;
        logic [AW-1:0] ad;
        logic [DW-1:0] held;
        nb = BURST ? int'(len) + 1 : 1;
        wait_req_ready();
        Req_Valid = 1'b1; Req_Write = 1'b0; Req_Addr = a; Req_Len = len;
        tick();
        Req_Valid = 1'b0; Req_Addr = AW'($urandom); Req_Len = LW'($urandom);
        Wr_Valid = 1'($urandom_range(1)); Wr_Data = DW'($urandom);
        e0 = en_cnt;
        for (int i = 0; i < nb; i++) begin
            ad = AW'(int'(a) + i);
            chk("rd_issue_en", 32'({Mem_En, Mem_Write_EN}), 32'd1);
            chk("rd_issue_addr", 32'(Mem_Address), 32'(ad));
            chk("rd_issue_valid_low", 32'(Rd_Valid), 32'd0);
            Rd_Ready = 1'($urandom_range(1));
            tick();
            chk("rd_valid", 32'(Rd_Valid), 32'd1);
            chk("rd_data", 32'(Rd_Data), 32'(ref_mem[ad]));
            chk("rd_wait_en", 32'(Mem_En), 32'd1);
            held = ref_mem[ad];
            s = int'($urandom_range(32'(smax), 32'(smin)));
            for (int j = 0; j < s; j++) begin
                Rd_Ready = 1'b0;
                tick();
                chk("rd_hold", 32'({Rd_Valid, Mem_En}), 32'd3);
                chk("rd_hold_data", 32'(Rd_Data), 32'(held));
            end
            Rd_Ready = 1'b1;
            tick();
            Rd_Ready = 1'b0;
            chk("rd_valid_drop", 32'(Rd_Valid), 32'd0);
        end
        Wr_Valid = 1'b0;
        chk("rd_idle_req_ready", 32'(Req_Ready), 32'd1);
        chk("rd_idle_busy", 32'(Busy), 32'd0);
        chk("rd_strobe_count", en_cnt - e0, 32'(nb));
    endtask

    initial begin
        logic [AW-1:0] a;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bram[i] = DW'($urandom);
            ref_mem[i] = bram[i];
        end

        // Reset state
        Reset = 1'b1;
        repeat (3) tick();
        check_reset_vals("reset");
        Reset = 1'b0;
        tick();
        chk("idle_req_ready", 32'(Req_Ready), 32'd1);

        // Single write and read-back at 0x10
        do_write(8'h10, 4'd0, 16'hBEEF, 1'b1, 0);
        do_read(8'h10, 4'd0, 0, 0);

        // Burst across the address wrap, then read back
        do_write(8'hFE, 4'd3, 16'd1, 1'b1, 0);
        do_read(8'hFE, 4'd3, 0, 0);

        // Write gaps and heavy read backpressure
        do_write(8'h40, 4'd2, 16'h0, 1'b0, 100);
        do_read(8'h40, 4'd2, 5, 5);

        // Len=3 request (one beat when bursts are compiled out)
        do_write(8'h80, 4'd3, 16'h0, 1'b0, 0);
        do_read(8'h80, 4'd3, 0, 1);

`ifdef MEMORY_MASTER_BURST_EN
        // Reset after the second beat of a four-beat write
        a = 8'h30;
        wait_req_ready();
        Req_Valid = 1'b1; Req_Write = 1'b1; Req_Addr = a; Req_Len = 4'd3;
        tick();
        Req_Valid = 1'b0; Req_Write = 1'b0;
        for (int i = 0; i < 2; i++) begin
            Wr_Valid = 1'b1; Wr_Data = DW'($urandom);
            ref_mem[AW'(int'(a) + i)] = Wr_Data;
            tick();
        end
        Wr_Valid = 1'b1; Wr_Data = DW'($urandom);
        Reset = 1'b1;
        tick();
        Wr_Valid = 1'b0;
        check_reset_vals("wr_abort");
        tick();
        chk("wr_abort_beat1", 32'(bram[AW'(int'(a) + 1)]), 32'(ref_mem[AW'(int'(a) + 1)]));
        chk("wr_abort_mem2", 32'(bram[AW'(int'(a) + 2)]), 32'(ref_mem[AW'(int'(a) + 2)]));
        chk("wr_abort_mem3", 32'(bram[AW'(int'(a) + 3)]), 32'(ref_mem[AW'(int'(a) + 3)]));
        Reset = 1'b0;
        tick();
`endif

        // Reset while read data is pending
        a = 8'h50;
        wait_req_ready();
        Req_Valid = 1'b1; Req_Write = 1'b0; Req_Addr = a; Req_Len = 4'd0;
        tick();
        Req_Valid = 1'b0;
        tick();
        chk("rd_abort_pending", 32'(Rd_Valid), 32'd1);
        Rd_Ready = 1'b0;
        Reset = 1'b1;
        tick();
        check_reset_vals("rd_abort");
        Reset = 1'b0;
        tick();
        chk("rd_abort_idle", 32'(Req_Ready), 32'd1);

        // Randomized traffic against the reference array
        for (int k = 0; k < 24; k++) begin
            a = AW'($urandom);
            if ($urandom_range(1) == 1)
                do_write(a, LW'($urandom), 16'h0, 1'b0, 30);
            else
                do_read(a, LW'($urandom), 0, 3);
        end

        chk("strobe_rules", viol, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_master.md
# memory_master

Bus-master front end for the single-port, negedge-clocked BRAM `Memory` block. It accepts read and write requests from the CPU/sequencer side over valid/ready handshakes. It drives the memory's active-low enable and write strobes plus its address and data lines, and returns captured read data over a valid/ready channel. Requests may be single-beat or, when compiled in, incrementing-address bursts.

## Interface
- AddrWidth, 8, memory address width; must match the attached `Memory`
- DataWidth, 16, memory data width; must match the attached `Memory`
- LenWidth, 4, width of burst length field (beats minus one)

- Clk  in  1  system clock; this block acts on posedge, the memory on negedge
- Reset  in  1  synchronous, active-high reset
- Req_Valid  in  1  request present
- Req_Ready  out  1  request accepted when high with Req_Valid at posedge
- Req_Write  in  1  1 = write request, 0 = read request
- Req_Addr  in  AddrWidth  start address
- Req_Len  in  LenWidth  number of beats minus one
- Wr_Data  in  DataWidth  write beat data
- Wr_Valid  in  1  write beat present
- Wr_Ready  out  1  write beat accepted when high with Wr_Valid
- Rd_Data  out  DataWidth  read beat data
- Rd_Valid  out  1  read beat present
- Rd_Ready  in  1  consumer takes read beat
- Busy  out  1  transfer in progress
- Mem_DIn  out  DataWidth  to memory DIn
- Mem_Address  out  AddrWidth  to memory Address
- Mem_Write_EN  out  1  to memory Write_EN; active low
- Mem_En  out  1  to memory Mem_En; active low
- Mem_DOut  in  DataWidth  from memory DOut

## Operation
- All outputs are registered on posedge Clk.
- Reset values:
  - Req_Ready=0, Wr_Ready=0, Rd_Valid=0, Busy=0
  - Mem_En=1, Mem_Write_EN=1
  - Mem_Address=0, Mem_DIn=0, Rd_Data=0
  - State=IDLE
- State machine:
  - IDLE: Req_Ready=1. A handshake latches the address into an address counter and Req_Len into a beat counter, sets Busy=1 and drops Req_Ready. Next state is WRITE if Req_Write, else RD_ISSUE.
  - WRITE: Wr_Ready=1. Each Wr_Valid&&Wr_Ready beat drives Mem_Address=addr, Mem_DIn=Wr_Data, Mem_En=0, Mem_Write_EN=0 for exactly the following cycle. The address counter then increments and the beat counter decrements. After the last beat: Wr_Ready=0, go to IDLE. If Wr_Valid is low, Mem_En=1 (no strobe) and the block waits indefinitely.
  - RD_ISSUE: one cycle with Mem_En=0, Mem_Write_EN=1, Mem_Address=addr. Next state is RD_WAIT.
  - RD_WAIT: at entry, Rd_Data is loaded from Mem_DOut and Rd_Valid=1; Mem_En=1. Rd_Data and Rd_Valid hold until Rd_Valid&&Rd_Ready. Then Rd_Valid=0 and the block goes to RD_ISSUE (beats remain, addr+1) or IDLE.
- Strobe rules:
  - Mem_En is never low in IDLE or RD_WAIT.
  - Mem_Write_EN is low only in cycles where Mem_En is low and a write is in progress.
- Address arithmetic: the counter is AddrWidth bits and wraps modulo 2^AddrWidth (0xFF+1 → 0x00 at default width); the burst continues across the wrap.
- Req_Len=0 gives 1 beat; the maximum gives 2^LenWidth beats.
- Wr_Valid is ignored outside WRITE, and Rd_Ready is ignored while Rd_Valid=0.
- Busy is 1 from the cycle after request acceptance until the cycle of return to IDLE; Req_Ready is 1 only in IDLE.
- Reset mid-transfer aborts the transfer: the next edge forces reset values, so no further strobes are issued. Beats already written stay written, and pending read data is discarded.

## Timing
- Request accepted at posedge 0 → first Mem_En low in cycle 1 (between posedge 0 and posedge 1). The memory samples at the negedge inside that cycle.
- Read: Rd_Valid=1 from posedge 1 (cycle 2), giving a request-to-data latency of 2 cycles. Mem_DOut is stable half a cycle before capture.
- Read throughput: at most 1 beat per 2 cycles with Rd_Ready held high.
- Write throughput: 1 beat per cycle with Wr_Valid held high. The strobe for the beat accepted at posedge k occupies cycle k+1.
- Return to IDLE: Req_Ready=1 the cycle after the final write strobe or the final read handshake. A new request is accepted no earlier than that cycle.

## Configuration
- MEMORY_MASTER_BURST_EN defined: Req_Len is honoured and multi-beat incrementing bursts operate as above.
- Undefined: Req_Len is ignored, every request is exactly one beat, and the beat and address counters reduce to plain registers. The port list is unchanged.

## Test plan
- Single write: Req_Write=1, Addr=0x10, Len=0, Wr_Data=0xBEEF → one cycle with Mem_En=0, Mem_Write_EN=0, Mem_Address=0x10, Mem_DIn=0xBEEF; then IDLE with Req_Ready=1.
- Single read: preload mem[0x10]=0xBEEF; read Addr=0x10 → Mem_En low exactly one cycle; Rd_Valid=1 and Rd_Data=0xBEEF two cycles after acceptance.
- Burst with wrap (BURST_EN): write Addr=0xFE, Len=3, data 1,2,3,4 → writes land at 0xFE, 0xFF, 0x00, 0x01. Reading the same range back returns 1,2,3,4 in order.
- Backpressure:
  - Read burst Len=2 with Rd_Ready low 5 cycles per beat → Rd_Data stable, no extra Mem_En pulses, 3 total strobes.
  - Write with Wr_Valid gaps → strobes occur only for accepted beats.
- Reset mid-burst: assert Reset after the 2nd beat of a 4-beat write → Mem_En=1 next cycle, mem[addr+2..3] unchanged, all outputs at reset values.
- Burst disabled (macro undefined): Len=3 request → exactly one strobe, Busy drops after one beat.
